// File: rtl/led_pwm_bank.sv
// Multi-channel LED/GPIO driver with a shared prescaled phase counter and per-channel
// OFF/ON/PWM/BLINK outputs. Define LED_PWM_STAGGER_EN to offset each channel's phase.
module led_pwm_bank #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int DIV_W    = 16,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_W-1:0]    div,
    input  logic                cfg_valid,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [WIDTH-1:0]    cfg_duty,
    output logic                cfg_ready,
    output logic                tick,
    output logic [CHANNELS-1:0] pwm_out
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    localparam logic [WIDTH-1:0] PH_MAX = '1;

    logic [DIV_W-1:0]    pre_reg;
    logic [WIDTH-1:0]    ph_reg;
    logic                tick_reg;
    logic                step;
    logic                wrap;
    logic                accept;
    logic [CHANNELS-1:0] pending;

    // >= rather than == so lowering div mid-count cannot strand the prescaler
    assign step = (pre_reg >= div);
    assign wrap = step && (ph_reg == PH_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_reg  <= '0;
            ph_reg   <= '0;
            tick_reg <= 1'b0;
        end else begin
            pre_reg  <= step ? '0 : pre_reg + 1'b1;
            if (step) begin
                ph_reg <= ph_reg + 1'b1;
            end
            tick_reg <= wrap;
        end
    end

    assign tick = tick_reg;

    // Indices with no channel stay ready; their writes match no channel and vanish.
    always_comb begin
        cfg_ready = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cfg_ch == CH_W'(c)) begin
                cfg_ready = !pending[c];
            end
        end
    end

    assign accept = cfg_valid && cfg_ready;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

            mode_t            shadow_mode_reg;
            mode_t            active_mode_reg;
            logic [WIDTH-1:0] shadow_duty_reg;
            logic [WIDTH-1:0] active_duty_reg;
            logic             pending_reg;
            logic             pwm_reg;
            logic             pwm_next;
            logic [WIDTH-1:0] phase;
            logic             sel;

`ifdef LED_PWM_STAGGER_EN
            localparam int OFS = gi * ((1 << WIDTH) / CHANNELS);
            assign phase = ph_reg + WIDTH'(OFS);
`else
            assign phase = ph_reg;
`endif

            assign sel = accept && (cfg_ch == CH_IDX);

            // A pending channel never accepts, so load-on-wrap and a new write cannot
            // collide; a write landing on the wrap cycle waits for the following wrap.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_mode_reg <= MODE_OFF;
                    shadow_duty_reg <= '0;
                    active_mode_reg <= MODE_OFF;
                    active_duty_reg <= '0;
                    pending_reg     <= 1'b0;
                end else begin
                    if (wrap && pending_reg) begin
                        active_mode_reg <= shadow_mode_reg;
                        active_duty_reg <= shadow_duty_reg;
                        pending_reg     <= 1'b0;
                    end
                    if (sel) begin
                        shadow_mode_reg <= mode_t'(cfg_mode);
                        shadow_duty_reg <= cfg_duty;
                        pending_reg     <= 1'b1;
                    end
                end
            end

            always_comb begin
                pwm_next = 1'b0;
                unique case (active_mode_reg)
                    MODE_OFF:   pwm_next = 1'b0;
                    MODE_ON:    pwm_next = 1'b1;
                    MODE_PWM:   pwm_next = (phase < active_duty_reg);
                    MODE_BLINK: pwm_next = phase[WIDTH-1];
                    default:    pwm_next = 1'b0;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pwm_reg <= 1'b0;
                end else begin
                    pwm_reg <= pwm_next;
                end
            end

            assign pending[gi] = pending_reg;
            assign pwm_out[gi] = pwm_reg;
        end
    endgenerate

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank with CHANNELS=2, WIDTH=4 (16-step period).
module tb_led_pwm_bank;

    logic       clk;
    logic       rst;
    logic [7:0] div;
    logic       cfg_valid;
    logic [0:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_duty;
    logic       cfg_ready;
    logic       tick;
    logic [1:0] pwm_out;

    int tests_run = 0;
    int tests_failed = 0;

    led_pwm_bank #(.CHANNELS(2), .WIDTH(4), .DIV_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .div       (div),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_duty  (cfg_duty),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .pwm_out   (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // Cycles from the current negedge until the negedge where tick is seen high.
    task automatic wait_tick(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n++;
            if (tick) return;
        end
        n = -1;
    endtask

    task automatic cfg_write(input logic ch, input logic [1:0] mode, input logic [3:0] duty);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_duty  = duty;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        rst = 1'b1; div = 8'd0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = 2'd0; cfg_duty = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm_out, 2'b00);
        check("rst_tick", tick, 1'b0);
        check("rst_ready", cfg_ready, 1'b1);
        rst = 1'b0;
        wait_tick(n);
        check("first_tick", n, 16);
        wait_tick(n);
        check("tick_period_div0", n, 16);

        // PWM duty 4 on ch0
        cfg_write(1'b0, 2'd2, 4'd4);
        check("ready_low_after_write", cfg_ready, 1'b0);
        wait_tick(n);
        check("ready_high_after_wrap", cfg_ready, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check($sformatf("pwm_duty4_%0d", i), pwm_out[0], ((i - 1) < 4));
        end
        // Now at the negedge where ph=0 again (tick cycle)
        check("tick_after_period", tick, 1'b1);

        // PWM duty 0 stays low for a full period
        cfg_write(1'b0, 2'd2, 4'd0);
        wait_tick(n);
        seen = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            seen = seen | pwm_out[0];
        end
        check("pwm_duty0_never_high", seen, 1'b0);

        // Prescaler div=2
        div = 8'd2;
        wait_tick(n);
        check("tick_period_div2_a", n, 48);
        wait_tick(n);
        check("tick_period_div2_b", n, 48);
        repeat (2) @(negedge clk);  // pre is now 2
        div = 8'd0;
        wait_tick(n);
        check("div_lowered_no_hang", n, 16);

        // Handshake: ch1 ON, held-off second write, ch0 write in between
        cfg_write(1'b1, 2'd1, 4'd0);
        cfg_ch = 1'b1;
        #1 check("ch1_ready_low", cfg_ready, 1'b0);
        cfg_write(1'b1, 2'd0, 4'd0);   // not accepted
        cfg_ch = 1'b0;
        #1 check("ch0_ready_while_ch1_pending", cfg_ready, 1'b1);
        @(negedge clk);
        cfg_write(1'b0, 2'd0, 4'd0);   // ch0 -> OFF, accepted
        check("ch0_ready_low_after_write", cfg_ready, 1'b0);
        cfg_ch = 1'b1;
        wait_tick(n);
        check("ch1_ready_high_after_wrap", cfg_ready, 1'b1);
        check("ch1_not_yet_on_at_ph0", pwm_out[1], 1'b0);
        @(negedge clk);
        check("ch1_on_after_ph0", pwm_out[1], 1'b1);
        check("ch0_off_after_wrap", pwm_out[0], 1'b0);
        wait_tick(n);
        @(negedge clk);
        check("ch1_held_write_dropped", pwm_out[1], 1'b1);

        // Write on the wrap cycle applies one period later
        repeat (14) @(negedge clk);    // ph=15, next posedge wraps
        cfg_write(1'b0, 2'd1, 4'd0);
        check("wrap_cycle_tick", tick, 1'b1);
        check("wrap_write_still_pending", cfg_ready, 1'b0);
        @(negedge clk);
        check("wrap_write_not_applied", pwm_out[0], 1'b0);
        wait_tick(n);
        check("wrap_write_ready_back", cfg_ready, 1'b1);
        @(negedge clk);
        check("wrap_write_applied", pwm_out[0], 1'b1);

        // BLINK on both channels
        wait_tick(n);
        cfg_write(1'b0, 2'd3, 4'd5);
        cfg_write(1'b1, 2'd3, 4'd9);
        wait_tick(n);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check($sformatf("blink_ch0_%0d", i), pwm_out[0], ((i - 1) >= 8));
`ifdef LED_PWM_STAGGER_EN
            check($sformatf("blink_ch1_%0d", i), pwm_out[1], ((i - 1) < 8));
`else
            check($sformatf("blink_ch1_%0d", i), pwm_out[1], ((i - 1) >= 8));
`endif
        end

        // Async reset with ch1 write pending
        cfg_write(1'b1, 2'd1, 4'd0);
        repeat (9) @(negedge clk);     // ph=9 reflected, ch0 blink high
        check("pre_areset_ch0_high", pwm_out[0], 1'b1);
        #2 rst = 1'b1;
        #1 check("areset_pwm_zero", pwm_out, 2'b00);
        check("areset_tick_zero", tick, 1'b0);
        cfg_ch = 1'b1;
        #0 check("areset_ch1_ready", cfg_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(n);
        check("tick_after_areset", n, 16);
        @(negedge clk);
        check("ch_off_after_areset", pwm_out, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/led_pwm_bank.md
# led_pwm_bank

Parametrised multi-channel LED/GPIO driver: the successor to the free-running counter blinker. A runtime prescaler and a shared phase counter drive per-channel PWM, blink, constant-on or off outputs. Channels are reconfigured through a valid/ready write port, and changes take effect glitch-free at the period boundary. The block sits between the on-chip oscillator clock and the board GPIO pins.

## Interface
- CHANNELS, 2, number of output channels (≥1).
- WIDTH, 8, phase counter / duty resolution in bits (≥2); period = 2^WIDTH steps.
- DIV_W, 16, prescaler divisor width.
- CH_W, max(1, clog2(CHANNELS)), channel index width (derived).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- div  in  DIV_W  prescale divisor; one phase step every div+1 clk cycles.
- cfg_valid  in  1  config write request.
- cfg_ch  in  CH_W  target channel.
- cfg_mode  in  2  0=OFF, 1=ON, 2=PWM, 3=BLINK.
- cfg_duty  in  WIDTH  PWM compare value.
- cfg_ready  out  1  write can be accepted for cfg_ch.
- tick  out  1  one-cycle pulse at each period wrap.
- pwm_out  out  CHANNELS  registered channel outputs.

## Operation
- Prescaler `pre` (DIV_W bits) increments each cycle. When pre ≥ div: pre←0 and the internal `step` is asserted for that cycle. The ≥ comparison prevents a hang when div is lowered mid-count. div=0 gives a step every cycle.
- Phase counter `ph` (WIDTH bits) increments on each step and wraps from 2^WIDTH−1 to 0. A wrap is a step with ph=2^WIDTH−1.
- Per channel, the block holds a shadow {mode,duty}, an active {mode,duty} and a pending flag.
- Write handshake:
  - cfg_ready = !pending[cfg_ch], combinational on cfg_ch.
  - A write is accepted when cfg_valid && cfg_ready. It stores {mode,duty} to the shadow and sets pending.
  - If cfg_ch ≥ CHANNELS: cfg_ready=1 and the write is accepted but discarded.
- On a wrap, every pending channel copies shadow to active and clears pending.
- A write accepted in the same cycle as a wrap is not applied at that wrap. Its pending flag stays set and it applies at the next wrap.
- Output function per channel c, evaluated on phase p (p=ph unless LED_PWM_STAGGER_EN):
  - OFF → 0.
  - ON → 1.
  - PWM → (p < duty), unsigned. duty=0 is always low; duty=2^WIDTH−1 is high for 2^WIDTH−1 of 2^WIDTH steps.
  - BLINK → p[WIDTH−1]; duty is ignored.
- Reset values: pre=0, ph=0, all shadow/active = OFF with duty 0, pending=0, pwm_out=0, tick=0, cfg_ready=1.

## Timing
- pwm_out[c] in cycle n+1 = f(active[c], ph) in cycle n. This is one cycle of latency and there is no combinational path from inputs to pwm_out.
- tick is registered. It is high for exactly one cycle, the cycle after the wrap step, which is the same cycle in which ph reads 0.
- An active update takes effect from ph=0. The first pwm_out reflecting it appears one cycle after ph becomes 0.
- cfg_ready falls in the cycle after an accepted write and rises in the cycle after the wrap that applies it.
- Tick period = (div+1)·2^WIDTH cycles with constant div.
- Asynchronous reset mid-operation: all state clears immediately. Pending writes are lost and pwm_out is 0 while rst is high. Counting restarts on the first clk edge after deassertion.

## Configuration
- LED_PWM_STAGGER_EN defined:
  - Channel c evaluates p = (ph + c·(2^WIDTH / CHANNELS)) mod 2^WIDTH, using integer division. This spreads switching edges across the period.
  - Applies to PWM and BLINK. tick and active-load timing are unchanged.
- Not defined: every channel uses p=ph, so all edges are phase-aligned.

## Test plan
- Reset, with CHANNELS=2, WIDTH=4, div=0: pulse rst for 3 cycles → pwm_out=0, tick=0, cfg_ready=1. First tick appears 16 cycles after rst release, then every 16 cycles.
- PWM: write ch0 PWM duty=4 → from the cycle after the next ph=0, pwm_out[0] is high 4 cycles and low 12 cycles, repeating. duty=0 → constantly 0.
- Prescale: div=2 → ph steps every 3 cycles and tick period = 48. Change div to 0 while pre=2 → a step occurs next cycle with no hang.
- Handshake:
  - Write ch1 ON → cfg_ready(ch1)=0 until the wrap.
  - A second write to ch1 is held off; a write to ch0 is accepted in the meantime.
  - pwm_out[1]=1 one cycle after ph=0.
  - A write accepted on the wrap cycle applies one period later.
- BLINK on ch0 with div=0 → pwm_out[0] is low for 8 cycles and high for 8 cycles. With LED_PWM_STAGGER_EN and ch1 also BLINK, ch1 leads ch0 by 8 steps, so the two channels are in antiphase.
- Async reset with ch0 active and a ch1 write pending: assert rst between clock edges → pwm_out goes to 0 immediately. After release, ch1 stays OFF at the next wrap.
